// File: rtl/gpu_pkg.sv
// Shared GPU definitions: texture loader state encoding and packet framing constants.
package gpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_HI = 3'd1,
        ADDR_LO = 3'd2,
        LEN_HI  = 3'd3,
        LEN_LO  = 3'd4,
        TEX_HI  = 3'd5,
        TEX_LO  = 3'd6,
        DONE    = 3'd7
    } loader_state_t;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;
    localparam int         TEXEL_BYTES = 2;

endpackage

// File: rtl/texture_loader.sv
// Texture upload front end: parses sync/address/count framed byte packets and
// writes 12-bit texels to sequential texture RAM addresses.
module texture_loader
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int COLOR_WIDTH  = 12,
    parameter int TEXTURE_SIZE = 64*64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [ADDR_WIDTH-1:0]  waddr,
    output logic [COLOR_WIDTH-1:0] wcolor,
    output logic                   wen,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    if (COLOR_WIDTH != 12) begin : g_bad_color_width
        $error("texture_loader: COLOR_WIDTH must be 12");
    end

    // One extra bit so a TEXTURE_SIZE of exactly 2^ADDR_WIDTH is representable
    localparam logic [ADDR_WIDTH:0] TEX_LIMIT = (ADDR_WIDTH+1)'(TEXTURE_SIZE);

    loader_state_t          state_r, next_state_s;
    logic [7:0]             addr_hi_r;
    logic [7:0]             len_hi_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [15:0]            cnt_r;
    logic [3:0]             nib_r;
    logic [ADDR_WIDTH-1:0]  waddr_r;
    logic [COLOR_WIDTH-1:0] wcolor_r;
    logic                   wen_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   ovf_r;
    logic                   ready_r;

    logic                   accept_s;
    logic                   in_range_s;
    logic                   issue_s;
    logic                   sync_s;
    logic                   tex_write_s;

    assign accept_s    = s_valid && ready_r;
    assign in_range_s  = ({1'b0, addr_r} < TEX_LIMIT);
    assign tex_write_s = issue_s && in_range_s;

    // Next-state decode and per-byte strobes
    always_comb begin
        next_state_s = state_r;
        issue_s      = 1'b0;
        sync_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && (s_data == LOADER_SYNC)) begin
                    next_state_s = ADDR_HI;
                    sync_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ADDR_HI: begin
                if (accept_s) next_state_s = ADDR_LO;
                else          next_state_s = ADDR_HI;
            end
            ADDR_LO: begin
                if (accept_s) next_state_s = LEN_HI;
                else          next_state_s = ADDR_LO;
            end
            LEN_HI: begin
                if (accept_s) next_state_s = LEN_LO;
                else          next_state_s = LEN_HI;
            end
            LEN_LO: begin
                if (accept_s) begin
                    if ({len_hi_r, s_data} == 16'd0) next_state_s = DONE;
                    else                             next_state_s = TEX_HI;
                end else begin
                    next_state_s = LEN_LO;
                end
            end
            TEX_HI: begin
                if (accept_s) next_state_s = TEX_LO;
                else          next_state_s = TEX_HI;
            end
            TEX_LO: begin
                if (accept_s) begin
                    issue_s = 1'b1;
                    if (cnt_r == 16'd1) next_state_s = DONE;
                    else                next_state_s = TEX_HI;
                end else begin
                    next_state_s = TEX_LO;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register and state-derived status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            ready_r <= (next_state_s != DONE);
            busy_r  <= (next_state_s != IDLE);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Header fields, running address, remaining count and pending nibble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hi_r <= 8'd0;
            len_hi_r  <= 8'd0;
            addr_r    <= '0;
            cnt_r     <= 16'd0;
            nib_r     <= 4'd0;
        end else if (accept_s) begin
            case (state_r)
                ADDR_HI: addr_hi_r <= s_data;
                ADDR_LO: addr_r    <= ADDR_WIDTH'({addr_hi_r, s_data});
                LEN_HI:  len_hi_r  <= s_data;
                LEN_LO:  cnt_r     <= {len_hi_r, s_data};
                TEX_HI:  nib_r     <= s_data[3:0];
                TEX_LO: begin
                    addr_r <= addr_r + ADDR_WIDTH'(1'b1);
                    cnt_r  <= cnt_r - 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Texture write port; address/color hold while no write is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_r    <= 1'b0;
            waddr_r  <= '0;
            wcolor_r <= '0;
        end else begin
            wen_r <= tex_write_s;
            if (tex_write_s) begin
                waddr_r  <= addr_r;
                wcolor_r <= COLOR_WIDTH'({nib_r, s_data});
            end
        end
    end

    // Sticky overflow, cleared when a new packet starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (sync_s) begin
            ovf_r <= 1'b0;
        end else if (issue_s && !in_range_s) begin
            ovf_r <= 1'b1;
        end
    end

    assign s_ready  = ready_r;
    assign waddr    = waddr_r;
    assign wcolor   = wcolor_r;
    assign wen      = wen_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = ovf_r;

endmodule
